// File: rtl/spi_frame_master.sv
// Framed SPI master: sends one byte per cs-low frame on mosi and captures the
// slave's framed reply on miso. Single clock, posedge only, shared with the slave.
module spi_frame_master #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 31
) (
    input  logic              clock_in,
    input  logic              rs,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy,
    output logic              cs,
    output logic              mosi,
    input  logic              miso
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_TOP  = BW'(DATA_W - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [2:0] {IDLE, SELECT, START, SHIFT, STOP, WAIT_RX, GAP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_HUNT, R_DATA, R_STOP, R_DONE} rx_state_t;

    tx_state_t         state_r, state_s;
    rx_state_t         rstate_r, rstate_s;
    logic [DATA_W-1:0] tx_sreg_r, tx_sreg_s;
    logic [BW-1:0]     tx_bit_r, tx_bit_s;
    logic [DATA_W-1:0] rx_sreg_r, rx_sreg_s;
    logic [BW-1:0]     rx_bit_r, rx_bit_s;
    logic [TW-1:0]     tout_r, tout_s;
    logic [GW-1:0]     gap_r, gap_s;
    logic              cs_r, cs_s;
    logic              mosi_r, mosi_s;
    logic              rx_valid_r, rx_err_r, err_s;
    logic [DATA_W-1:0] rx_data_r, data_s;
    logic              busy_r, ready_r;
    logic              accept_s, done_s;

    assign accept_s = tx_valid & ready_r;

    // Rx hunter: armed on accept, finds the start bit, shifts the reply, checks stop or times out
    always_comb begin
        rstate_s  = rstate_r;
        rx_sreg_s = rx_sreg_r;
        rx_bit_s  = rx_bit_r;
        tout_s    = tout_r;
        done_s    = 1'b0;
        err_s     = rx_err_r;
        data_s    = rx_data_r;
        case (rstate_r)
            R_IDLE: begin
                if (accept_s) begin
                    rstate_s = R_HUNT;
                    tout_s   = '0;
                end else begin
                    rstate_s = R_IDLE;
                end
            end
            R_HUNT: begin
                tout_s = tout_r + 1'b1;
                if (miso == 1'b0) begin
                    rstate_s = R_DATA;
                    rx_bit_s = BIT_TOP;
                end else if (tout_r == TO_LAST) begin
                    rstate_s = R_DONE;
                    done_s   = 1'b1;
                    err_s    = 1'b1;
                    data_s   = '0;
                end else begin
                    rstate_s = R_HUNT;
                end
            end
            R_DATA: begin
                rx_sreg_s = {rx_sreg_r[DATA_W-2:0], miso};
                rx_bit_s  = rx_bit_r - 1'b1;
                if (rx_bit_r == '0) begin
                    rstate_s = R_STOP;
                end else begin
                    rstate_s = R_DATA;
                end
            end
            R_STOP: begin
                rstate_s = R_DONE;
                done_s   = 1'b1;
                err_s    = ~miso;
                data_s   = rx_sreg_r;
            end
            R_DONE:  rstate_s = R_IDLE;
            default: rstate_s = R_IDLE;
        endcase
    end

    // Tx FSM next state; rx completion overrides whatever the tx path is doing
    always_comb begin
        state_s   = state_r;
        tx_sreg_s = tx_sreg_r;
        tx_bit_s  = tx_bit_r;
        gap_s     = gap_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s   = SELECT;
                    tx_sreg_s = tx_data;
                end else begin
                    state_s = IDLE;
                end
            end
            SELECT: state_s = START;
            START: begin
                state_s  = SHIFT;
                tx_bit_s = BIT_TOP;
            end
            SHIFT: begin
                if (tx_bit_r == '0) begin
                    state_s = STOP;
                end else begin
                    tx_bit_s = tx_bit_r - 1'b1;
                end
            end
            STOP:    state_s = WAIT_RX;
            WAIT_RX: state_s = WAIT_RX;
            GAP: begin
                if (gap_r == GAP_ONE) begin
                    state_s = IDLE;
                end else begin
                    gap_s = gap_r - GAP_ONE;
                end
            end
            default: state_s = IDLE;
        endcase
        // cs stays high GAP_CYCLES cycles in total, the final one being IDLE
        if (done_s) begin
            gap_s = GAP_LOAD;
            if (GAP_CYCLES > 1) begin
                state_s = GAP;
            end else begin
                state_s = IDLE;
            end
        end else begin
            gap_s = gap_s;
        end
    end

    // Line values decoded from the next state so cs/mosi come straight from flops
    always_comb begin
        cs_s = (state_s == IDLE) || (state_s == GAP);
        case (state_s)
            START:   mosi_s = 1'b0;
            SHIFT:   mosi_s = tx_sreg_s[tx_bit_s];
            default: mosi_s = 1'b1;
        endcase
    end

    // State and output registers
    always_ff @(posedge clock_in) begin
        if (rs) begin
            state_r    <= IDLE;
            rstate_r   <= R_IDLE;
            tx_sreg_r  <= '0;
            tx_bit_r   <= '0;
            rx_sreg_r  <= '0;
            rx_bit_r   <= '0;
            tout_r     <= '0;
            gap_r      <= '0;
            cs_r       <= 1'b1;
            mosi_r     <= 1'b1;
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            rx_data_r  <= '0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_s;
            rstate_r   <= rstate_s;
            tx_sreg_r  <= tx_sreg_s;
            tx_bit_r   <= tx_bit_s;
            rx_sreg_r  <= rx_sreg_s;
            rx_bit_r   <= rx_bit_s;
            tout_r     <= tout_s;
            gap_r      <= gap_s;
            cs_r       <= cs_s;
            mosi_r     <= mosi_s;
            rx_valid_r <= done_s;
            rx_err_r   <= err_s;
            rx_data_r  <= data_s;
            busy_r     <= (state_s != IDLE);
            ready_r    <= (state_s == IDLE);
        end
    end

    assign tx_ready = ready_r;
    assign busy     = busy_r;
    assign cs       = cs_r;
    assign mosi     = mosi_r;
    assign rx_valid = rx_valid_r;
    assign rx_err   = rx_err_r;
    assign rx_data  = rx_data_r;

endmodule
